// File: rtl/player_bullet.sv
// Player bullet: spawns from the cannon on a fire edge, climbs SPEED pixels
// per frame, and ends on a hit or when it leaves the top of the screen. A
// cooldown period follows each bullet. The pixel renderer is combinational.
module player_bullet #(
  parameter int SPEED     = 8,
  parameter int BULLET_W  = 2,
  parameter int BULLET_H  = 8,
  parameter int SPAWN_Y   = 432,
  parameter int SPAWN_OFS = 7,
  parameter int COOLDOWN  = 15
) (
  input  logic       v_sync,
  input  logic       rst,
  input  logic       fire,
  input  logic [9:0] cannon_x_pos,
  input  logic       hit,
  input  logic [9:0] pix_x,
  input  logic [9:0] pix_y,
  output logic [9:0] bullet_x,
  output logic [9:0] bullet_y,
  output logic       bullet_active,
  output logic [7:0] shots_fired,
  output logic       bullet_graphics
);

  typedef enum logic [1:0] {
    S_IDLE     = 2'd0,
    S_FLYING   = 2'd1,
    S_COOLDOWN = 2'd2
  } state_t;

  // Counter value loaded on cooldown entry; COOLDOWN frames are spent there.
  localparam logic [7:0]  CD_LOAD   = (COOLDOWN == 0) ? 8'd0 : 8'(COOLDOWN - 1);
  localparam logic [10:0] X_LIMIT   = 11'(640 - BULLET_W);
  localparam logic [10:0] SPEED_11  = 11'(SPEED);

  state_t      r_state;
  state_t      w_state_next;
  logic        r_fire_prev;
  logic [7:0]  r_cd_cnt;
  logic [9:0]  r_bullet_x;
  logic [9:0]  r_bullet_y;
  logic [7:0]  r_shots;

  logic        w_fire_edge;
  logic        w_spawn;
  logic        w_off_top;
  logic        w_move;
  logic        w_enter_cd;
  logic [10:0] w_spawn_sum;
  logic [9:0]  w_spawn_x;

  assign w_fire_edge = fire & ~r_fire_prev;
  assign w_spawn     = (r_state == S_IDLE) && w_fire_edge;
  assign w_off_top   = ({1'b0, r_bullet_y} < SPEED_11);
  // Hit wins over both movement and the off-screen check.
  assign w_move      = (r_state == S_FLYING) && !hit && !w_off_top;
  assign w_enter_cd  = (w_state_next == S_COOLDOWN) && (r_state == S_FLYING);

  // Spawn X clamped so the whole bullet stays on the 640-pixel line.
  assign w_spawn_sum = {1'b0, cannon_x_pos} + 11'(SPAWN_OFS);
  assign w_spawn_x   = (w_spawn_sum > X_LIMIT) ? X_LIMIT[9:0] : w_spawn_sum[9:0];

  // State register.
  always_ff @(posedge v_sync or posedge rst) begin
    if (rst) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  // Next-state logic; fire edges outside IDLE and hits outside FLYING are dropped.
  always_comb begin
    w_state_next = r_state;
    case (r_state)
      S_IDLE: begin
        if (w_fire_edge) begin
          w_state_next = S_FLYING;
        end
      end
      S_FLYING: begin
        if (hit || w_off_top) begin
          w_state_next = (COOLDOWN == 0) ? S_IDLE : S_COOLDOWN;
        end
      end
      S_COOLDOWN: begin
        if (r_cd_cnt == 8'd0) begin
          w_state_next = S_IDLE;
        end
      end
      default: w_state_next = S_IDLE;
    endcase
  end

  // Datapath: fire history, position, shot counter and cooldown counter.
  always_ff @(posedge v_sync or posedge rst) begin
    if (rst) begin
      r_fire_prev <= 1'b1;
      r_bullet_x  <= 10'd0;
      r_bullet_y  <= 10'd0;
      r_shots     <= 8'd0;
      r_cd_cnt    <= 8'd0;
    end else begin
      r_fire_prev <= fire;
      if (w_spawn) begin
        r_bullet_x <= w_spawn_x;
        r_bullet_y <= 10'(SPAWN_Y);
        r_shots    <= r_shots + 8'd1;
      end else if (w_move) begin
        r_bullet_y <= r_bullet_y - 10'(SPEED);
      end
      if (w_enter_cd) begin
        r_cd_cnt <= CD_LOAD;
      end else if ((r_state == S_COOLDOWN) && (r_cd_cnt != 8'd0)) begin
        r_cd_cnt <= r_cd_cnt - 8'd1;
      end
    end
  end

  // Outputs: activity flag from state and the bullet rectangle hit-test.
  always_comb begin
    bullet_active   = (r_state == S_FLYING);
    bullet_graphics = bullet_active
                    && ({1'b0, pix_x} >= {1'b0, r_bullet_x})
                    && ({1'b0, pix_x} <  ({1'b0, r_bullet_x} + 11'(BULLET_W)))
                    && ({1'b0, pix_y} >= {1'b0, r_bullet_y})
                    && ({1'b0, pix_y} <  ({1'b0, r_bullet_y} + 11'(BULLET_H)));
  end

  assign bullet_x    = r_bullet_x;
  assign bullet_y    = r_bullet_y;
  assign shots_fired = r_shots;

endmodule

// File: tb/tb_player_bullet.sv
// Directed bench for player_bullet with default parameters.
module tb_player_bullet;

  logic       v_sync;
  logic       rst;
  logic       fire;
  logic [9:0] cannon_x_pos;
  logic       hit;
  logic [9:0] pix_x;
  logic [9:0] pix_y;
  logic [9:0] bullet_x;
  logic [9:0] bullet_y;
  logic       bullet_active;
  logic [7:0] shots_fired;
  logic       bullet_graphics;

  int checks   = 0;
  int failures = 0;

  player_bullet dut (
    .v_sync          (v_sync),
    .rst             (rst),
    .fire            (fire),
    .cannon_x_pos    (cannon_x_pos),
    .hit             (hit),
    .pix_x           (pix_x),
    .pix_y           (pix_y),
    .bullet_x        (bullet_x),
    .bullet_y        (bullet_y),
    .bullet_active   (bullet_active),
    .shots_fired     (shots_fired),
    .bullet_graphics (bullet_graphics)
  );

  initial begin
    v_sync = 1'b0;
    forever #5 v_sync = ~v_sync;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // Apply inputs, then advance one frame and settle just after the edge.
  task automatic step(input logic f, input logic h);
    fire = f;
    hit  = h;
    @(posedge v_sync);
    #1;
  endtask

  initial begin
    rst = 1'b1; fire = 1'b0; hit = 1'b0; cannon_x_pos = 10'd312;
    pix_x = 10'd0; pix_y = 10'd0;
    #12;
    chk("rst_active", bullet_active, 0);
    chk("rst_x", bullet_x, 0);
    chk("rst_y", bullet_y, 0);
    chk("rst_shots", shots_fired, 0);
    chk("rst_gfx", bullet_graphics, 0);
    rst = 1'b0;
    step(0, 0);
    step(0, 0);

    // Basic flight: edge 1 spawns.
    step(1, 0);
    chk("spawn_x", bullet_x, 319);
    chk("spawn_y", bullet_y, 432);
    chk("spawn_shots", shots_fired, 1);
    chk("spawn_active", bullet_active, 1);
    for (int e = 2; e <= 55; e++) step(0, 0);
    chk("e55_y", bullet_y, 0);
    chk("e55_active", bullet_active, 1);
    // Edges 56..71 with fire toggling (high on even edges): nothing spawns.
    for (int e = 56; e <= 71; e++) begin
      step((e % 2) == 0, 0);
      chk($sformatf("cd_e%0d_shots", e), shots_fired, 1);
      chk($sformatf("cd_e%0d_active", e), bullet_active, 0);
    end
    chk("e71_y_held", bullet_y, 0);
    chk("e71_x_held", bullet_x, 319);
    step(1, 0);
    chk("e72_shots", shots_fired, 2);
    chk("e72_active", bullet_active, 1);

    // Hit priority on the 3rd edge after spawn.
    step(0, 0);
    chk("hp1_y", bullet_y, 424);
    step(0, 0);
    chk("hp2_y", bullet_y, 416);
    step(0, 1);
    chk("hp3_active", bullet_active, 0);
    chk("hp3_y", bullet_y, 416);
    // 14 more cooldown frames with hit ignored; fire edge on the last cooldown frame is dropped.
    for (int e = 0; e < 14; e++) step(0, 1);
    chk("cd14_active", bullet_active, 0);
    step(1, 0);
    chk("cd_last_drop", shots_fired, 2);
    chk("cd_last_active", bullet_active, 0);
    step(0, 0);

    // Right clamp, hit in IDLE ignored.
    cannon_x_pos = 10'd636;
    step(1, 1);
    chk("clamp_x", bullet_x, 638);
    chk("clamp_shots", shots_fired, 3);
    chk("clamp_active", bullet_active, 1);
    step(0, 1);
    chk("clamp_hit_end", bullet_active, 0);
    for (int e = 0; e < 15; e++) step(0, 0);

    // Render: bring a bullet to (100,200).
    cannon_x_pos = 10'd93;
    step(1, 0);
    chk("rnd_x", bullet_x, 100);
    chk("rnd_shots", shots_fired, 4);
    for (int e = 0; e < 29; e++) step(0, 0);
    chk("rnd_y", bullet_y, 200);
    chk("rnd_active", bullet_active, 1);
    pix_x = 10'd100; pix_y = 10'd200; #1;
    chk("gfx_100_200", bullet_graphics, 1);
    pix_x = 10'd101; pix_y = 10'd207; #1;
    chk("gfx_101_207", bullet_graphics, 1);
    pix_x = 10'd102; pix_y = 10'd200; #1;
    chk("gfx_102_200", bullet_graphics, 0);
    pix_x = 10'd100; pix_y = 10'd208; #1;
    chk("gfx_100_208", bullet_graphics, 0);
    pix_x = 10'd99;  pix_y = 10'd200; #1;
    chk("gfx_99_200", bullet_graphics, 0);
    pix_x = 10'd100; pix_y = 10'd200;

    // Asynchronous reset mid-flight, with fire held through release.
    @(negedge v_sync);
    fire = 1'b1;
    rst  = 1'b1;
    #1;
    chk("arst_active", bullet_active, 0);
    chk("arst_gfx", bullet_graphics, 0);
    chk("arst_shots", shots_fired, 0);
    chk("arst_x", bullet_x, 0);
    chk("arst_y", bullet_y, 0);
    @(negedge v_sync);
    rst = 1'b0;
    for (int e = 0; e < 10; e++) step(1, 0);
    chk("held_shots", shots_fired, 0);
    chk("held_active", bullet_active, 0);
    step(0, 0);
    chk("rel_shots", shots_fired, 0);
    step(1, 0);
    chk("repress_shots", shots_fired, 1);
    chk("repress_active", bullet_active, 1);
    chk("repress_x", bullet_x, 100);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
